// File: rtl/div_8bits_seq.sv
// Iterative restoring divider producing one quotient bit per clock, signed or unsigned.
// Optional divide-by-zero detection is enabled by defining DIV_BYZERO_EN.
module div_8bits_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Signed,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quot,
  output logic [WIDTH-1:0] Rem,
  output logic             DivZero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic             accept_s;
  logic [WIDTH-1:0] d_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    cnt_r;
  logic             neg_q_r, neg_r_r;
  logic             busy_r, done_r;
  logic [WIDTH-1:0] quot_r, rem_r;
  logic [WIDTH:0]   shift_s;
  logic [WIDTH-1:0] diff_s;
  logic             ge_s;
`ifdef DIV_BYZERO_EN
  localparam logic [WIDTH-1:0] ZERO_W = '0;
  logic             byzero_s;
  logic             dz_op_r;
  logic             dz_r;
  logic [WIDTH-1:0] a_raw_r;
`endif

  // Two's-complement negate; 0x80 maps onto itself and is then read as unsigned 128.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    neg_w = (~v) + ONE_W;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic use_sign);
    if (use_sign && v[WIDTH-1]) begin
      mag = neg_w(v);
    end else begin
      mag = v;
    end
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and start acceptance.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
`ifdef DIV_BYZERO_EN
    byzero_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (Start) begin
          accept_s = 1'b1;
`ifdef DIV_BYZERO_EN
          if (B == ZERO_W) begin
            byzero_s = 1'b1;
            state_s  = FIN;
          end else begin
            state_s  = CALC;
          end
`else
          state_s = CALC;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CNT_LAST) begin
          state_s = FIN;
        end else begin
          state_s = CALC;
        end
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Trial subtraction: the shifted remainder needs WIDTH+1 bits; a successful result fits WIDTH.
  always_comb begin
    shift_s = {r_r, q_r[WIDTH-1]};
    ge_s    = (shift_s >= {1'b0, d_r});
    diff_s  = shift_s[WIDTH-1:0] - d_r;
  end

  // Operand capture, iteration, sign fix-up and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_r     <= '0;
      q_r     <= '0;
      r_r     <= '0;
      cnt_r   <= '0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      quot_r  <= '0;
      rem_r   <= '0;
`ifdef DIV_BYZERO_EN
      dz_op_r <= 1'b0;
      dz_r    <= 1'b0;
      a_raw_r <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            d_r     <= mag(B, Signed);
            q_r     <= mag(A, Signed);
            r_r     <= '0;
            cnt_r   <= '0;
            neg_q_r <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r_r <= Signed & A[WIDTH-1];
            busy_r  <= 1'b1;
`ifdef DIV_BYZERO_EN
            dz_op_r <= byzero_s;
            dz_r    <= 1'b0;
            a_raw_r <= A;
`endif
          end else begin
            busy_r <= 1'b0;
          end
        end
        CALC: begin
          r_r   <= ge_s ? diff_s : shift_s[WIDTH-1:0];
          q_r   <= {q_r[WIDTH-2:0], ge_s};
          cnt_r <= cnt_r + CNT_ONE;
        end
        FIN: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
`ifdef DIV_BYZERO_EN
          if (dz_op_r) begin
            quot_r <= '1;
            rem_r  <= a_raw_r;
            dz_r   <= 1'b1;
          end else begin
            quot_r <= neg_q_r ? neg_w(q_r) : q_r;
            rem_r  <= neg_r_r ? neg_w(r_r) : r_r;
          end
`else
          quot_r <= neg_q_r ? neg_w(q_r) : q_r;
          rem_r  <= neg_r_r ? neg_w(r_r) : r_r;
`endif
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = busy_r;
  assign Done = done_r;
  assign Quot = quot_r;
  assign Rem  = rem_r;
`ifdef DIV_BYZERO_EN
  assign DivZero = dz_r;
`else
  assign DivZero = 1'b0;
`endif

endmodule

// File: tb/tb_div_8bits_seq.sv
// Self-checking bench for div_8bits_seq: directed cases plus random operands checked
// against plain integer division. Covers DIV_BYZERO_EN when that macro is defined.
module tb_div_8bits_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         Start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Signed = 1'b0;
  logic         Busy, Done, DivZero;
  logic [W-1:0] Quot, Rem;

  int n_cmp = 0;
  int n_bad = 0;

  div_8bits_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .Start(Start), .A(A), .B(B), .Signed(Signed),
    .Busy(Busy), .Done(Done), .Quot(Quot), .Rem(Rem), .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer division truncates toward zero and % follows the dividend's sign.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] q, output logic [W-1:0] r);
    int ai, bi, qi, ri;
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
      ai = s ? int'($signed(a)) : int'(a);
      bi = s ? int'($signed(b)) : int'(b);
      qi = ai / bi;
      ri = ai % bi;
      q  = qi[W-1:0];
      r  = ri[W-1:0];
    end
  endtask

  // Issue one op from a point just after a rising edge; optionally pulse Start mid-op.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int poke_at, input logic check_result);
    logic [W-1:0] eq, er, hold_q, hold_r;
    int exp_lat, n;
    bit seen;
    model(a, b, s, eq, er);
    exp_lat = W + 1;
`ifdef DIV_BYZERO_EN
    if (b == '0) exp_lat = 1;
`endif
    hold_q = Quot;
    hold_r = Rem;
    A = a; B = b; Signed = s; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    A = $urandom; B = $urandom; Signed = $urandom;
    check("busy_after_accept", {15'd0, Busy}, 16'd1);
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= 3 * W; i++) begin
      Start = (i == poke_at) ? 1'b1 : 1'b0;
      if (i == poke_at) begin A = 8'd9; B = 8'd3; end
      @(posedge clk); #1;
      Start = 1'b0;
      if (Done) begin
        seen = 1'b1;
        n = i;
        break;
      end
      check("busy_during_op", {15'd0, Busy}, 16'd1);
      check("quot_held", {8'd0, Quot}, {8'd0, hold_q});
      check("rem_held", {8'd0, Rem}, {8'd0, hold_r});
    end
    check("done_seen", {15'd0, seen}, 16'd1);
    check("latency", 16'(n), 16'(exp_lat));
    check("busy_at_done", {15'd0, Busy}, 16'd0);
    if (check_result) begin
      check("quot", {8'd0, Quot}, {8'd0, eq});
      check("rem", {8'd0, Rem}, {8'd0, er});
    end
`ifdef DIV_BYZERO_EN
    check("divzero", {15'd0, DivZero}, {15'd0, (b == '0)});
`else
    check("divzero", {15'd0, DivZero}, 16'd0);
`endif
  endtask

  initial begin
    logic [W-1:0] ra, rb, eq, er;
    logic         rs;

    // Reset held for three cycles.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", {15'd0, Busy}, 16'd0);
    check("rst_done", {15'd0, Done}, 16'd0);
    check("rst_quot", {8'd0, Quot}, 16'd0);
    check("rst_rem", {8'd0, Rem}, 16'd0);
    check("rst_divzero", {15'd0, DivZero}, 16'd0);
    @(posedge clk); #1;

    // Directed cases with fixed spec values.
    run_op(8'd200, 8'd7, 1'b0, 0, 1'b1);
    check("u200_7_q", {8'd0, Quot}, 16'd28);
    check("u200_7_r", {8'd0, Rem}, 16'd4);
    @(posedge clk); #1;
    check("done_one_cycle", {15'd0, Done}, 16'd0);
    check("result_held", {8'd0, Quot}, 16'd28);

    run_op(8'hF9, 8'd2, 1'b1, 0, 1'b1);
    check("sm7_2_q", {8'd0, Quot}, 16'h00FD);
    check("sm7_2_r", {8'd0, Rem}, 16'h00FF);
    run_op(8'd7, 8'hFE, 1'b1, 0, 1'b1);
    check("s7_m2_q", {8'd0, Quot}, 16'h00FD);
    check("s7_m2_r", {8'd0, Rem}, 16'h0001);
    run_op(8'h80, 8'hFF, 1'b1, 0, 1'b1);
    check("sovf_q", {8'd0, Quot}, 16'h0080);
    check("sovf_r", {8'd0, Rem}, 16'h0000);
    run_op(8'h80, 8'hFF, 1'b0, 0, 1'b1);
    check("u80_ff_q", {8'd0, Quot}, 16'h0000);
    check("u80_ff_r", {8'd0, Rem}, 16'h0080);
    run_op(8'h35, 8'h00, 1'b0, 0, 1'b1);
    check("udz_q", {8'd0, Quot}, 16'h00FF);
    check("udz_r", {8'd0, Rem}, 16'h0035);

    // Start mid-op is ignored; Start in the Done cycle is accepted.
    run_op(8'd100, 8'd9, 1'b0, 4, 1'b1);
    check("poke_q", {8'd0, Quot}, 16'd11);
    check("poke_r", {8'd0, Rem}, 16'd1);
    run_op(8'd9, 8'd3, 1'b0, 0, 1'b1);
    check("b2b_q", {8'd0, Quot}, 16'd3);
    check("b2b_r", {8'd0, Rem}, 16'd0);

`ifdef DIV_BYZERO_EN
    run_op(8'h35, 8'h00, 1'b1, 0, 1'b1);
    check("sdz_q", {8'd0, Quot}, 16'h00FF);
    check("sdz_r", {8'd0, Rem}, 16'h0035);
    check("sdz_flag", {15'd0, DivZero}, 16'd1);
    run_op(8'd10, 8'd5, 1'b0, 0, 1'b1);
    check("dz_cleared", {15'd0, DivZero}, 16'd0);
`endif

    // Reset on the 4th CALC edge aborts the op.
    A = 8'd100; B = 8'd3; Signed = 1'b0; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", {15'd0, Busy}, 16'd0);
    check("abort_done", {15'd0, Done}, 16'd0);
    check("abort_quot", {8'd0, Quot}, 16'd0);
    check("abort_rem", {8'd0, Rem}, 16'd0);
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", {15'd0, Done}, 16'd0);
    end

    // Random operands against the reference model.
    for (int k = 0; k < 60; k++) begin
      ra = $urandom;
      rb = $urandom;
      rs = $urandom;
      if (k % 7 == 3) rb = 8'd1;
      if (k % 11 == 5) ra = 8'h80;
`ifndef DIV_BYZERO_EN
      if (rs && rb == '0) rb = 8'd5;
`endif
      run_op(ra, rb, rs, 0, 1'b1);
      model(ra, rb, rs, eq, er);
      if (k % 2 == 0) begin
        @(posedge clk); #1;
        check("rnd_done_low", {15'd0, Done}, 16'd0);
        check("rnd_hold_q", {8'd0, Quot}, {8'd0, eq});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
